// File: rtl/ann_weight_trainer.sv
// Perceptron training engine that feeds the ANN ALU weight-load path.
// It evaluates each labelled sample with its own copy of the weights.
// After a misprediction it updates the weights and presents them to the ALU for one cycle.
module ann_weight_trainer #(
  parameter int unsigned LR_SHIFT  = 0,
  parameter int unsigned BIAS_STEP = 1,
  parameter int unsigned EPOCH_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        target,
  output logic        pred,
  output logic        pred_valid,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_c,
  output logic [2:0]  alu_src,
  output logic        converged,
  output logic [15:0] err_total
);

  // The counter must hold EPOCH_LEN, because err_cnt can reach it within one epoch.
  localparam int CW = $clog2(EPOCH_LEN + 1) + 1;

  typedef enum logic [1:0] {IDLE, EVAL, DECIDE, WRITE} state_t;

  state_t        r_state;
  state_t        w_next;

  logic [31:0]   r_w1, r_w2, r_w3;
  logic [31:0]   r_x1, r_x2;
  logic          r_target;
  logic [31:0]   r_sum;
  logic [CW-1:0] r_sampleCnt;
  logic [CW-1:0] r_errCnt;
  logic [15:0]   r_errTotal;
  logic          r_converged;
  logic          r_pred;
  logic          r_predValid;

  logic          w_accept;
  logic          w_y;
  logic          w_err;
  logic [31:0]   w_d1, w_d2, w_bias;
  logic [CW-1:0] w_errCntNext;
  logic          w_epochEnd;

  assign w_accept     = in_valid & in_ready;
  assign w_y          = ~r_sum[31];
  assign w_err        = (w_y != r_target);
  assign w_d1         = $signed(r_x1) >>> LR_SHIFT;
  assign w_d2         = $signed(r_x2) >>> LR_SHIFT;
  assign w_bias       = 32'(BIAS_STEP);
  assign w_errCntNext = r_errCnt + {{(CW-1){1'b0}}, w_err};
  assign w_epochEnd   = (r_sampleCnt == CW'(EPOCH_LEN - 1));

  // State register. A reset returns the block to IDLE at once, which also stops any ALU write in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state. A request from clear goes straight to a write of zero weights.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (clear) w_next = WRITE;
               else if (w_accept) w_next = EVAL;
      EVAL:    w_next = DECIDE;
      DECIDE:  w_next = w_err ? WRITE : IDLE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from the state. alu_src depends only on the state, so rst drops it immediately.
  always_comb begin
    in_ready = (r_state == IDLE) & ~clear;
    alu_src  = (r_state == WRITE) ? 3'b101 : 3'b000;
  end

  // Datapath: sample capture, weighted sum, perceptron update and epoch bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w1        <= '0;
      r_w2        <= '0;
      r_w3        <= '0;
      r_x1        <= '0;
      r_x2        <= '0;
      r_target    <= 1'b0;
      r_sum       <= '0;
      r_sampleCnt <= '0;
      r_errCnt    <= '0;
      r_errTotal  <= '0;
      r_converged <= 1'b0;
      r_pred      <= 1'b0;
      r_predValid <= 1'b0;
    end else begin
      r_predValid <= (r_state == DECIDE);
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_w1        <= '0;
            r_w2        <= '0;
            r_w3        <= '0;
            r_sampleCnt <= '0;
            r_errCnt    <= '0;
            r_errTotal  <= '0;
            r_converged <= 1'b0;
          end else if (w_accept) begin
            r_x1     <= x1;
            r_x2     <= x2;
            r_target <= target;
          end
        end
        EVAL: begin
          r_sum <= r_w1 * r_x1 + r_w2 * r_x2 + r_w3;
        end
        DECIDE: begin
          r_pred <= w_y;
          if (w_err) begin
            if (r_target) begin
              r_w1 <= r_w1 + w_d1;
              r_w2 <= r_w2 + w_d2;
              r_w3 <= r_w3 + w_bias;
            end else begin
              r_w1 <= r_w1 - w_d1;
              r_w2 <= r_w2 - w_d2;
              r_w3 <= r_w3 - w_bias;
            end
            if (r_errTotal != 16'hFFFF) r_errTotal <= r_errTotal + 16'd1;
          end
          if (w_epochEnd) begin
            r_converged <= (w_errCntNext == '0);
            r_sampleCnt <= '0;
            r_errCnt    <= '0;
          end else begin
            r_sampleCnt <= r_sampleCnt + {{(CW-1){1'b0}}, 1'b1};
            r_errCnt    <= w_errCntNext;
          end
        end
        default: ;
      endcase
    end
  end

  assign pred       = r_pred;
  assign pred_valid = r_predValid;
  assign alu_a      = r_w1;
  assign alu_b      = r_w2;
  assign alu_c      = r_w3;
  assign converged  = r_converged;
  assign err_total  = r_errTotal;

endmodule

// File: tb/tb_ann_weight_trainer.sv
// Testbench for ann_weight_trainer.
// A behavioural perceptron model inside the bench predicts every output.
module tb_ann_weight_trainer;

  localparam int unsigned LR    = 0;
  localparam int unsigned BIAS  = 1;
  localparam int unsigned EPOCH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic        target = 1'b0;
  logic        pred;
  logic        pred_valid;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_src;
  logic        converged;
  logic [15:0] err_total;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic signed [31:0] mW1, mW2, mW3;
  int mSampleCnt, mErrCnt, mErrTotal;
  bit mConverged;

  ann_weight_trainer #(.LR_SHIFT(LR), .BIAS_STEP(BIAS), .EPOCH_LEN(EPOCH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .target(target), .pred(pred), .pred_valid(pred_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_src(alu_src),
    .converged(converged), .err_total(err_total)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it when the observed and expected values differ
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mW1 = 0; mW2 = 0; mW3 = 0;
    mSampleCnt = 0; mErrCnt = 0; mErrTotal = 0;
    mConverged = 0;
  endtask

  // Send one sample and check the prediction, the ALU write and the bookkeeping cycle by cycle
  task automatic applyStimulus(input logic [31:0] ax1, input logic [31:0] ax2, input logic at);
    logic signed [31:0] sum;
    bit y, err;
    int waitCnt;
    sum = mW1 * $signed(ax1) + mW2 * $signed(ax2) + mW3;
    y   = (sum >= 0);
    err = (y != at);
    if (err) begin
      if (at) begin
        mW1 = mW1 + ($signed(ax1) >>> LR); mW2 = mW2 + ($signed(ax2) >>> LR); mW3 = mW3 + BIAS;
      end else begin
        mW1 = mW1 - ($signed(ax1) >>> LR); mW2 = mW2 - ($signed(ax2) >>> LR); mW3 = mW3 - BIAS;
      end
      mErrCnt++;
      if (mErrTotal < 65535) mErrTotal++;
    end
    mSampleCnt++;
    if (mSampleCnt == EPOCH) begin
      mConverged = (mErrCnt == 0);
      mSampleCnt = 0;
      mErrCnt = 0;
    end

    waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput("ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    x1 = ax1; x2 = ax2; target = at; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("pv_early", 32'(pred_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("pv_pulse", 32'(pred_valid), 32'd1);
    checkOutput("pred", 32'(pred), 32'(y));
    checkOutput("err_total", 32'(err_total), 32'(mErrTotal));
    checkOutput("converged", 32'(converged), 32'(mConverged));
    checkOutput("alu_src", 32'(alu_src), err ? 32'd5 : 32'd0);
    if (err) begin
      checkOutput("alu_a", alu_a, mW1);
      checkOutput("alu_b", alu_b, mW2);
      checkOutput("alu_c", alu_c, mW3);
      @(posedge clk); #1;
      checkOutput("alu_src_after", 32'(alu_src), 32'd0);
      checkOutput("pv_drop", 32'(pred_valid), 32'd0);
    end
    checkOutput("ready_back", 32'(in_ready), 32'd1);
  endtask

  // Assert clear together with a valid sample and check that clear wins
  task automatic doClear();
    clear = 1'b1; in_valid = 1'b1; x1 = 32'd7; x2 = 32'd7; target = 1'b1;
    #1;
    checkOutput("clr_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    checkOutput("clr_src", 32'(alu_src), 32'd5);
    checkOutput("clr_a", alu_a, 32'd0);
    checkOutput("clr_b", alu_b, 32'd0);
    checkOutput("clr_c", alu_c, 32'd0);
    checkOutput("clr_errtot", 32'(err_total), 32'd0);
    checkOutput("clr_conv", 32'(converged), 32'd0);
    @(posedge clk); #1;
    checkOutput("clr_idle_src", 32'(alu_src), 32'd0);
    checkOutput("clr_idle_ready", 32'(in_ready), 32'd1);
    checkOutput("clr_no_pv", 32'(pred_valid), 32'd0);
    resetModel();
  endtask

  initial begin
    int ex;
    resetModel();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pred", 32'(pred), 32'd0);
    checkOutput("rst_pv", 32'(pred_valid), 32'd0);
    checkOutput("rst_src", 32'(alu_src), 32'd0);
    checkOutput("rst_a", alu_a, 32'd0);
    checkOutput("rst_errtot", 32'(err_total), 32'd0);
    checkOutput("rst_conv", 32'(converged), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // First sample mispredicts, then the same sample is classified correctly
    applyStimulus(32'd4, 32'd8, 1'b0);
    checkOutput("tp_a", alu_a, 32'hFFFFFFFC);
    checkOutput("tp_b", alu_b, 32'hFFFFFFF8);
    checkOutput("tp_c", alu_c, 32'hFFFFFFFF);
    applyStimulus(32'd4, 32'd8, 1'b0);
    checkOutput("tp_errtot", 32'(err_total), 32'd1);

    // Convergence on a separable set, then an injected mislabelled sample
    doClear();
    for (int ep = 0; ep < 8 && !mConverged; ep++) begin
      for (int s = 0; s < int'(EPOCH); s++) begin
        ex = ($urandom_range(0, 1) == 1) ? 5 : -5;
        applyStimulus(32'(ex), 32'd0, ex > 0);
      end
    end
    checkOutput("conv_set", 32'(converged), 32'd1);
    applyStimulus(32'd5, 32'd0, 1'b0);
    for (int s = 1; s < int'(EPOCH); s++) begin
      ex = ($urandom_range(0, 1) == 1) ? 5 : -5;
      applyStimulus(32'(ex), 32'd0, ex > 0);
    end
    checkOutput("conv_drop", 32'(converged), 32'd0);

    // Wrap-around of the product and the weights
    doClear();
    applyStimulus(32'h40000000, 32'd0, 1'b0);
    checkOutput("wrap_a1", alu_a, 32'hC0000000);
    checkOutput("wrap_c1", alu_c, 32'hFFFFFFFF);
    applyStimulus(32'd4, 32'd0, 1'b1);
    checkOutput("wrap_a2", alu_a, 32'hC0000004);
    checkOutput("wrap_b2", alu_b, 32'd0);
    checkOutput("wrap_c2", alu_c, 32'd0);

    // Random samples
    for (int i = 0; i < 24; i++) begin
      applyStimulus(32'($signed($urandom_range(0, 200)) - 100),
                    32'($signed($urandom_range(0, 200)) - 100),
                    1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a WRITE cycle
    doClear();
    x1 = 32'd4; x2 = 32'd8; target = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    checkOutput("mid_src_pre", 32'(alu_src), 32'd5);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_src", 32'(alu_src), 32'd0);
    checkOutput("mid_a", alu_a, 32'd0);
    checkOutput("mid_pv", 32'(pred_valid), 32'd0);
    checkOutput("mid_pred", 32'(pred), 32'd0);
    checkOutput("mid_errtot", 32'(err_total), 32'd0);
    #1 rst = 1'b0;
    resetModel();
    @(posedge clk); #1;
    applyStimulus(32'd1, 32'd1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
